// File: rtl/controle_rodadas.sv
// Round-control FSM for the memory game: sequences the datapath through rounds and reports the outcome.
// Optional espera_jogada timeout timer is built only when CONTROLE_RODADAS_TIMEOUT_EN is defined.
module controle_rodadas #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada,
    input  logic       igual,
    input  logic       enderecoIgualLimite,
    input  logic       fimL,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraL,
    output logic       contaL,
    output logic       zeraR,
    output logic       registraR,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic       pronto,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIO_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMO        = 4'h6,
        PROXIMA_RODADA = 4'h8,
        FIM_ACERTO     = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERRO       = 4'hE
    } estado_t;

    estado_t estado_q;
    estado_t estado_d;
    logic    expirou;

    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("controle_rodadas: TIMEOUT_CYCLES must be at least 1");
    end

`ifdef CONTROLE_RODADAS_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;

    // Counts only while staying in espera_jogada, so every entry (including from proximo) starts at 0.
    always_comb begin
        timer_d = '0;
        if ((estado_q == ESPERA_JOGADA) && (estado_d == ESPERA_JOGADA)) begin
            timer_d = timer_q + TW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign expirou = (estado_q == ESPERA_JOGADA) && (timer_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign expirou = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL: begin
                if (iniciar) estado_d = PREPARACAO;
            end
            PREPARACAO:     estado_d = INICIO_RODADA;
            INICIO_RODADA:  estado_d = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                // jogada wins over an expiring timer in the same cycle
                if (jogada) begin
                    estado_d = REGISTRA;
                end else if (expirou) begin
                    estado_d = FIM_TIMEOUT;
                end
            end
            REGISTRA:       estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!igual) begin
                    estado_d = FIM_ERRO;
                end else if (!enderecoIgualLimite) begin
                    estado_d = PROXIMO;
                end else if (!fimL) begin
                    estado_d = PROXIMA_RODADA;
                end else begin
                    estado_d = FIM_ACERTO;
                end
            end
            PROXIMO:        estado_d = ESPERA_JOGADA;
            PROXIMA_RODADA: estado_d = INICIO_RODADA;
            FIM_ACERTO, FIM_TIMEOUT, FIM_ERRO: begin
                if (iniciar) estado_d = PREPARACAO;
            end
            default:        estado_d = INICIAL;
        endcase
    end

    // Moore outputs: decoded from the registered state only.
    always_comb begin
        zeraE     = 1'b0;
        contaE    = 1'b0;
        zeraL     = 1'b0;
        contaL    = 1'b0;
        zeraR     = 1'b0;
        registraR = 1'b0;
        acertou   = 1'b0;
        errou     = 1'b0;
        timeout   = 1'b0;
        pronto    = 1'b0;
        case (estado_q)
            PREPARACAO: begin
                zeraE = 1'b1;
                zeraL = 1'b1;
                zeraR = 1'b1;
            end
            INICIO_RODADA:  zeraE     = 1'b1;
            REGISTRA:       registraR = 1'b1;
            PROXIMO:        contaE    = 1'b1;
            PROXIMA_RODADA: contaL    = 1'b1;
            FIM_ACERTO: begin
                acertou = 1'b1;
                pronto  = 1'b1;
            end
            FIM_ERRO: begin
                errou  = 1'b1;
                pronto = 1'b1;
            end
            FIM_TIMEOUT: begin
`ifdef CONTROLE_RODADAS_TIMEOUT_EN
                timeout = 1'b1;
`endif
                pronto  = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_controle_rodadas.sv
// Self-checking bench for controle_rodadas: directed vector table, timeout sequences and a randomized model run.
module tb_controle_rodadas;

    localparam int TO = 10;

    localparam logic [9:0] O_ZE = 10'b1000000000;
    localparam logic [9:0] O_CE = 10'b0100000000;
    localparam logic [9:0] O_ZL = 10'b0010000000;
    localparam logic [9:0] O_CL = 10'b0001000000;
    localparam logic [9:0] O_ZR = 10'b0000100000;
    localparam logic [9:0] O_RR = 10'b0000010000;
    localparam logic [9:0] O_AC = 10'b0000001000;
    localparam logic [9:0] O_ER = 10'b0000000100;
    localparam logic [9:0] O_TO = 10'b0000000010;
    localparam logic [9:0] O_PR = 10'b0000000001;
    localparam logic [9:0] O_NO = 10'b0000000000;

    logic clock = 1'b0;
    logic reset, iniciar, jogada, igual, enderecoIgualLimite, fimL;
    logic zeraE, contaE, zeraL, contaL, zeraR, registraR;
    logic acertou, errou, timeout, pronto;
    logic [3:0] db_estado;
    logic [9:0] outs;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    controle_rodadas #(.TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
        .igual(igual), .enderecoIgualLimite(enderecoIgualLimite), .fimL(fimL),
        .zeraE(zeraE), .contaE(contaE), .zeraL(zeraL), .contaL(contaL),
        .zeraR(zeraR), .registraR(registraR), .acertou(acertou), .errou(errou),
        .timeout(timeout), .pronto(pronto), .db_estado(db_estado)
    );

    assign outs = {zeraE, contaE, zeraL, contaL, zeraR, registraR, acertou, errou, timeout, pronto};

    typedef struct packed {
        logic       rst, ini, jog, igu, eil, fim;
        logic [3:0] st;
        logic [9:0] o;
    } vec_t;

    vec_t vecs[$];
    logic [13:0] exp_q[$];

    function automatic vec_t mk(logic rst, logic ini, logic jog, logic igu, logic eil, logic fim,
                                logic [3:0] st, logic [9:0] o);
        vec_t v;
        v.rst = rst; v.ini = ini; v.jog = jog; v.igu = igu; v.eil = eil; v.fim = fim;
        v.st = st; v.o = o;
        return v;
    endfunction

    // Drive inputs away from the active edge, then let one rising edge happen and settle.
    task automatic apply(input logic rst, input logic ini, input logic jog, input logic igu,
                         input logic eil, input logic fim);
        @(negedge clock);
        reset = rst; iniciar = ini; jogada = jog; igual = igu;
        enderecoIgualLimite = eil; fimL = fim;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] st, input logic [9:0] o);
        total++;
        if (db_estado !== st || outs !== o) begin
            bad++;
            $display("FAIL %s: got estado=%h outs=%b, want estado=%h outs=%b", name, db_estado, outs, st, o);
        end
    endtask

    task automatic step_chk(input string name, input logic ini, input logic jog, input logic igu,
                            input logic eil, input logic fim, input logic [3:0] st, input logic [9:0] o);
        apply(1'b0, ini, jog, igu, eil, fim);
        check(name, st, o);
    endtask

    // Reference model: game rules as plain integers plus a count of cycles already waited for a play.
`ifdef CONTROLE_RODADAS_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    int m_st = 0;
    int m_wait = 0;

    function automatic logic [9:0] outs_for(int code);
        if (code == 1)  return O_ZE | O_ZL | O_ZR;
        if (code == 2)  return O_ZE;
        if (code == 4)  return O_RR;
        if (code == 6)  return O_CE;
        if (code == 8)  return O_CL;
        if (code == 10) return O_AC | O_PR;
        if (code == 13) return O_TO | O_PR;
        if (code == 14) return O_ER | O_PR;
        return O_NO;
    endfunction

    function automatic void model_step(logic rst, logic ini, logic jog, logic igu, logic eil, logic fim);
        int nxt;
        bit waiting;
        if (rst) begin
            m_st = 0;
            m_wait = 0;
            return;
        end
        nxt = m_st;
        waiting = (m_st == 3);
        if (m_st == 0 || m_st == 10 || m_st == 13 || m_st == 14) begin
            if (ini) nxt = 1;
        end else if (m_st == 1 || m_st == 8) begin
            nxt = 2;
        end else if (m_st == 2 || m_st == 6) begin
            nxt = 3;
        end else if (m_st == 4) begin
            nxt = 5;
        end else if (waiting) begin
            if (jog) nxt = 4;
            else if (TO_EN && (m_wait + 1 == TO)) nxt = 13;
        end else if (m_st == 5) begin
            if (!igu) nxt = 14;
            else if (!eil) nxt = 6;
            else if (!fim) nxt = 8;
            else nxt = 10;
        end
        m_wait = (waiting && nxt == 3) ? m_wait + 1 : 0;
        m_st = nxt;
    endfunction

    initial begin
        reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0;
        enderecoIgualLimite = 1'b0; fimL = 1'b0;

        // Directed table: full game paths, ignored inputs, and reset from comparacao.
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 4'h0, O_NO));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'h0, O_NO));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 4'h1, O_ZE | O_ZL | O_ZR));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'h2, O_ZE));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'h3, O_NO));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'h3, O_NO));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 4'h4, O_RR));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 4'h5, O_NO));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 4'h6, O_CE));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'h3, O_NO));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 4'h4, O_RR));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'h5, O_NO));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 4'h8, O_CL));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'h2, O_ZE));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'h3, O_NO));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 4'h4, O_RR));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'h5, O_NO));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 4'hA, O_AC | O_PR));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'hA, O_AC | O_PR));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 4'hA, O_AC | O_PR));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 4'h1, O_ZE | O_ZL | O_ZR));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'h2, O_ZE));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'h3, O_NO));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 4'h4, O_RR));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'h5, O_NO));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 4'hE, O_ER | O_PR));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 4'hE, O_ER | O_PR));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 4'h1, O_ZE | O_ZL | O_ZR));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'h2, O_ZE));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'h3, O_NO));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 4'h4, O_RR));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 4'h5, O_NO));
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 4'h0, O_NO));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 4'h0, O_NO));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].rst, vecs[i].ini, vecs[i].jog, vecs[i].igu, vecs[i].eil, vecs[i].fim);
            check($sformatf("vec%0d", i), vecs[i].st, vecs[i].o);
        end

        // Multi-cycle waits in espera_jogada.
        apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("seq_reset", 4'h0, O_NO);
        step_chk("seq_prep", 1, 0, 0, 0, 0, 4'h1, O_ZE | O_ZL | O_ZR);
        step_chk("seq_ini_rod", 0, 0, 0, 0, 0, 4'h2, O_ZE);
        step_chk("seq_espera", 0, 0, 0, 0, 0, 4'h3, O_NO);
`ifdef CONTROLE_RODADAS_TIMEOUT_EN
        for (int i = 1; i < TO; i++) step_chk($sformatf("wait%0d", i), 0, 0, 0, 0, 0, 4'h3, O_NO);
        step_chk("timeout_fire", 0, 0, 0, 0, 0, 4'hD, O_TO | O_PR);
        step_chk("timeout_hold", 0, 1, 1, 1, 1, 4'hD, O_TO | O_PR);
        step_chk("timeout_restart", 1, 0, 0, 0, 0, 4'h1, O_ZE | O_ZL | O_ZR);
        step_chk("r_ini_rod", 0, 0, 0, 0, 0, 4'h2, O_ZE);
        step_chk("r_espera", 0, 0, 0, 0, 0, 4'h3, O_NO);
        for (int i = 1; i < TO; i++) step_chk($sformatf("rwait%0d", i), 0, 0, 0, 0, 0, 4'h3, O_NO);
        step_chk("jogada_last_cycle", 0, 1, 0, 0, 0, 4'h4, O_RR);
        step_chk("p_comp", 0, 0, 0, 0, 0, 4'h5, O_NO);
        step_chk("p_proximo", 0, 0, 1, 0, 0, 4'h6, O_CE);
        step_chk("p_espera", 0, 0, 0, 0, 0, 4'h3, O_NO);
        for (int i = 1; i < TO; i++) step_chk($sformatf("pwait%0d", i), 0, 0, 0, 0, 0, 4'h3, O_NO);
        step_chk("timeout_after_proximo", 0, 0, 0, 0, 0, 4'hD, O_TO | O_PR);
`else
        for (int i = 1; i <= 3 * TO; i++) step_chk($sformatf("nowait%0d", i), 0, 0, 0, 0, 0, 4'h3, O_NO);
`endif

        // Randomized run against the model; starts from a reset so both sides agree.
        m_st = 0;
        m_wait = 0;
        for (int c = 0; c < 3000; c++) begin
            logic r_rst, r_ini, r_jog, r_igu, r_eil, r_fim;
            logic [13:0] got, want;
            r_rst = (c == 0) || ($urandom_range(63) == 0);
            r_ini = ($urandom_range(7) == 0);
            r_jog = ($urandom_range(5) == 0);
            r_igu = ($urandom_range(7) != 0);
            r_eil = ($urandom_range(2) == 0);
            r_fim = ($urandom_range(3) == 0);
            model_step(r_rst, r_ini, r_jog, r_igu, r_eil, r_fim);
            exp_q.push_back({4'(m_st), outs_for(m_st)});
            apply(r_rst, r_ini, r_jog, r_igu, r_eil, r_fim);
            got = {db_estado, outs};
            want = exp_q.pop_front();
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL rand%0d: got estado=%h outs=%b, want estado=%h outs=%b",
                         c, got[13:10], got[9:0], want[13:10], want[9:0]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
